// File: rtl/scalar_wb_arbiter.sv
// Writeback arbiter for a scalar core: two small writeback FIFOs (ALU, LSU) share one
// register-file write port under 1-bit round-robin, plus a pending-write scoreboard
// that answers three source-register busy queries.
module scalar_wb_arbiter #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        alu_valid,
    input  logic [3:0]  alu_rd,
    input  logic [31:0] alu_wd,
    output logic        alu_ready,

    input  logic        lsu_valid,
    input  logic [3:0]  lsu_rd,
    input  logic [31:0] lsu_wd,
    output logic        lsu_ready,

    input  logic        issue_valid,
    input  logic [3:0]  issue_rd,

    input  logic [3:0]  rs1,
    input  logic [3:0]  rs2,
    input  logic [3:0]  rs3,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        rs3_busy,

    output logic        wr_enable,
    output logic [3:0]  RD,
    output logic [31:0] WD,
    output logic        grant_lsu
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [3:0]  rd;
        logic [31:0] wd;
    } entry_t;

    // Index 0 is the ALU requester, index 1 the LSU requester.
    entry_t [1:0] in_entry;
    entry_t [1:0] head;
    logic   [1:0] in_valid;
    logic   [1:0] ready;
    logic   [1:0] push;
    logic   [1:0] pop;
    logic   [1:0] not_empty;

    logic        prio_q, prio_d;
    logic        grant;
    logic        sel_lsu;
    entry_t      head_sel;
    logic [15:0] pending_q, pending_d;

    assign in_entry[0] = {alu_rd, alu_wd};
    assign in_entry[1] = {lsu_rd, lsu_wd};
    assign in_valid    = {lsu_valid, alu_valid};
    assign alu_ready   = ready[0];
    assign lsu_ready   = ready[1];
    assign push        = in_valid & ready;

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        entry_t          mem_q [DEPTH];
        logic [PtrW-1:0] wptr_q, rptr_q;
        logic [CntW-1:0] cnt_q;

        // Ready depends only on registered occupancy, never on valid.
        assign ready[g]     = (cnt_q < CntW'(DEPTH));
        assign not_empty[g] = (cnt_q != '0);
        assign head[g]      = mem_q[rptr_q];

        // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (push[g]) wptr_q <= wptr_q + PtrW'(1);
                if (pop[g])  rptr_q <= rptr_q + PtrW'(1);
                case ({push[g], pop[g]})
                    2'b10:   cnt_q <= cnt_q + CntW'(1);
                    2'b01:   cnt_q <= cnt_q - CntW'(1);
                    default: cnt_q <= cnt_q;
                endcase
            end
        end

        // Entry storage; contents are don't-care while the slot is not counted.
        always_ff @(posedge clk) begin
            if (push[g]) mem_q[wptr_q] <= in_entry[g];
        end
    end

    // Round-robin grant: a lone non-empty FIFO wins, otherwise the pointer decides.
    always_comb begin
        grant     = |not_empty;
        sel_lsu   = not_empty[1] & (~not_empty[0] | prio_q);
        prio_d    = prio_q;
        pop       = 2'b00;
        head_sel  = head[sel_lsu];
        wr_enable = 1'b0;
        RD        = '0;
        WD        = '0;
        grant_lsu = 1'b0;
        if (grant) begin
            prio_d    = ~sel_lsu;
            pop       = sel_lsu ? 2'b10 : 2'b01;
            // rd=0 entries are drained without touching the register file.
            wr_enable = (head_sel.rd != 4'd0);
            RD        = head_sel.rd;
            WD        = head_sel.wd;
            grant_lsu = sel_lsu;
        end
    end

    // Scoreboard next state: clear on write, then set on issue so a same-cycle set wins.
    always_comb begin
        pending_d = pending_q;
        if (wr_enable) pending_d[RD] = 1'b0;
        if (issue_valid && (issue_rd != 4'd0)) pending_d[issue_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // Priority pointer and scoreboard registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q    <= 1'b0;
            pending_q <= '0;
        end else begin
            prio_q    <= prio_d;
            pending_q <= pending_d;
        end
    end

    // Busy queries read registered state only; no bypass from the write port.
    assign rs1_busy = pending_q[rs1];
    assign rs2_busy = pending_q[rs2];
    assign rs3_busy = pending_q[rs3];

endmodule

// File: doc/scalar_wb_arbiter.md
SCALAR_WB_ARBITER -- requirements
Module: scalar_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning per-requester FIFO depth in entries (power of two, 2..8).
REQ-002 The block SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have ports alu_valid  input  1, alu_rd  input  4 and alu_wd  input  32, meaning the ALU writeback request, destination and data.
REQ-005 The block SHALL have port alu_ready  output  1  ALU FIFO can accept an entry.
REQ-006 The block SHALL have ports lsu_valid  input  1, lsu_rd  input  4, lsu_wd  input  32 and lsu_ready  output  1, meaning the load-unit writeback request with the same semantics as the ALU ports.
REQ-007 The block SHALL have ports issue_valid  input  1 and issue_rd  input  4, meaning an instruction issued that will write issue_rd.
REQ-008 The block SHALL have ports rs1, rs2, rs3  input  4, meaning the source register queries.
REQ-009 The block SHALL have ports rs1_busy, rs2_busy, rs3_busy  output  1, meaning the queried register has a pending write.
REQ-010 The block SHALL have ports wr_enable  output  1, RD  output  4 and WD  output  32, meaning it drives the register-file write port.
REQ-011 The block SHALL have port grant_lsu  output  1, meaning the current write comes from the LSU FIFO (0 = ALU).

Function
REQ-012 The block SHALL transfer an entry into a FIFO on a clock edge where valid and ready are both 1; valid with ready=0 SHALL be ignored.
REQ-013 The ready signal SHALL equal "FIFO count < DEPTH", registered-state only, with no combinational dependence on valid.
REQ-014 Each FIFO SHALL preserve order and hold its count in 0..DEPTH; read and write pointers SHALL wrap modulo DEPTH.
REQ-015 Simultaneous push and pop on one FIFO SHALL leave the count unchanged; push on full SHALL be impossible per REQ-013.
REQ-016 The arbiter SHALL be round-robin with a 1-bit priority pointer: if exactly one FIFO is non-empty it is granted; if both are non-empty the FIFO named by the pointer is granted.
REQ-017 After any grant, the pointer SHALL move to the non-granted requester.
REQ-018 Each cycle with a grant SHALL pop exactly one entry from the granted FIFO; no grant SHALL occur when both FIFOs are empty.
REQ-019 WD, RD and grant_lsu SHALL be combinational from the granted FIFO head.
REQ-020 wr_enable SHALL be 1 iff a grant occurs and head rd != 0; an rd=0 entry SHALL be popped silently.
REQ-021 Latency: an entry accepted at edge N SHALL appear on the write port no earlier than the cycle after edge N, with no combinational input-to-output path.
REQ-022 Throughput SHALL be one write per cycle; with both FIFOs continuously non-empty, grants SHALL alternate ALU, LSU, ALU, ...
REQ-023 The scoreboard SHALL be a 16-bit pending vector; bit 0 SHALL be constant 0.
REQ-024 issue_valid with issue_rd != 0 SHALL set pending[issue_rd] at the edge.
REQ-025 A write with wr_enable=1 SHALL clear pending[RD] at the edge.
REQ-026 When a set and a clear target the same register in the same cycle, set SHALL win.
REQ-027 rsN_busy SHALL equal pending[rsN] with no bypass; it SHALL still read 1 in the cycle the clearing write occurs.
REQ-028 Re-issue to an already pending register SHALL keep the bit set; the first matching write clears it.

Reset
REQ-029 While rst=1, all FIFO counts and pointers, the priority pointer (to ALU) and the pending vector SHALL be 0.
REQ-030 While rst=1, the outputs SHALL be wr_enable=0, RD=0, WD=0, grant_lsu=0, alu_ready=1, lsu_ready=1 and rsN_busy=0.
REQ-031 Reset mid-operation SHALL discard all queued entries with no write issued; operation SHALL resume on the first edge after rst deasserts.

Verification
REQ-032 ALU push rd=3, wd=0xDEADBEEF at edge 1 -> next cycle wr_enable=1, RD=3, WD=0xDEADBEEF, grant_lsu=0; then idle.
REQ-033 ALU and LSU each push 2 entries (rd 1,2 and 4,5) in the same cycles -> write order 1,4,2,5 with grant_lsu 0,1,0,1.
REQ-034 DEPTH=2, LSU pushes 3 back-to-back while the ALU FIFO holds priority and is kept non-empty -> lsu_ready=0 after 2 entries; no entry lost; FIFO order preserved.
REQ-035 issue rd=7, then rs2=7 -> rs2_busy=1; the rd=7 write edge clears it; rs2_busy=0 the following cycle. Same-cycle issue rd=7 plus write rd=7 -> stays 1.
REQ-036 Push rd=0 -> popped with wr_enable=0; issue rd=0 -> rs1=0 busy stays 0.
REQ-037 Assert rst with 2 entries queued and pending[9]=1 -> wr_enable=0 immediately, both readies=1, rs busy for 9 =0; no write after release.
